program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 159 +++++++++++++++
 tb/tb_program_loader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: streams a host program into instruction memory, then boots
// and supervises one CPU run.
//
// Session flow: IDLE/DONE --start--> LOAD --last word--> BOOT (1 cycle)
//               --> RUN --EOE--> DONE
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           one-cycle pulse starting a session (ignored while busy)
//   load_valid/load_data/load_last/load_ready
//                   host word stream; a word is taken when valid & ready
//   mem_we/mem_addr/mem_wdata
//                   instruction memory write port, one cycle after a handshake
//   cpu_reset       held high everywhere except RUN
//   EOE             end of execution from the CPU (only sampled in RUN)
//   busy/done       session status (busy in LOAD/BOOT/RUN, done in DONE)
//   cycle_count     saturating count of RUN cycles
//   error           truncated load (memory filled without load_last) or
//                   watchdog expiry
//
// Build option: define LOADER_TIMEOUT_EN to end RUN with error once
// cycle_count reaches TIMEOUT_CYCLES without EOE.
module program_loader #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int CYCLE_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   load_valid,
  input  logic [DATA_WIDTH-1:0]  load_data,
  input  logic                   load_last,
  output logic                   load_ready,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  output logic                   cpu_reset,
  input  logic                   EOE,
  output logic                   busy,
  output logic                   done,
  output logic [CYCLE_WIDTH-1:0] cycle_count,
  output logic                   error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_BOOT,
    S_RUN,
    S_DONE
  } state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  ptr;
  logic                   handshake;
  logic                   ptr_at_end;
  logic [CYCLE_WIDTH-1:0] count_inc;

  assign handshake  = load_valid & load_ready;
  assign ptr_at_end = (ptr == '1);
  // Saturating increment: the counter sticks at all-ones.
  assign count_inc  = (cycle_count == '1) ? cycle_count
                                          : cycle_count + CYCLE_WIDTH'(1);

`ifdef LOADER_TIMEOUT_EN
  localparam logic [CYCLE_WIDTH-1:0] TIMEOUT_LIMIT = CYCLE_WIDTH'(TIMEOUT_CYCLES);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Status outputs are registered alongside each state transition so they
  // change exactly when the state does.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      ptr         <= '0;
      load_ready  <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_reset   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      cycle_count <= '0;
      error       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_LOAD;
            ptr         <= '0;
            cycle_count <= '0;
            error       <= 1'b0;
            load_ready  <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
          end
        end

        S_LOAD: begin
          if (handshake) begin
            mem_we    <= 1'b1;
            mem_addr  <= ptr;
            mem_wdata <= load_data;
            // Filling the last address without load_last ends the load as
            // truncated; the pointer is held rather than wrapped.
            if (load_last || ptr_at_end) begin
              state      <= S_BOOT;
              load_ready <= 1'b0;
              if (!load_last) begin
                error <= 1'b1;
              end
            end
            if (!ptr_at_end) begin
              ptr <= ptr + ADDR_WIDTH'(1);
            end
          end
        end

        S_BOOT: begin
          state     <= S_RUN;
          cpu_reset <= 1'b0;
        end

        S_RUN: begin
          cycle_count <= count_inc;
          if (EOE) begin
            state     <= S_DONE;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
`ifdef LOADER_TIMEOUT_EN
          else if (count_inc >= TIMEOUT_LIMIT) begin
            state     <= S_DONE;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            error     <= 1'b1;
          end
`endif
        end

        default: begin
          state      <= S_IDLE;
          load_ready <= 1'b0;
          cpu_reset  <= 1'b1;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: expected memory writes are queued
// when a handshake is driven and popped by an independent write monitor;
// session-level status is predicted from the loader's rules.
module tb_program_loader;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int CW = 32;
  localparam int TO = 20;
`ifdef LOADER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_last = 1'b0;
  logic          EOE = 1'b0;
  logic          load_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic [CW-1:0] cycle_count;
  logic          error;

  program_loader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .CYCLE_WIDTH(CW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_last(load_last),
    .load_ready(load_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset),
    .EOE(EOE),
    .busy(busy),
    .done(done),
    .cycle_count(cycle_count),
    .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t           exp_q[$];
  logic [DW-1:0] words[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write monitor: every mem_we cycle must match the oldest queued write,
  // including the cycle it was predicted for.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(e.addr));
        chk("wr_data", 64'(mem_wdata), 64'(e.data));
        chk("wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      wr_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_write: got mem_we 0 expected write addr %0h data %0h", e.addr, e.data);
    end
  end

  task automatic reset_checks(input string tag);
    @(negedge clk);
    chk({tag, "_load_ready"}, 64'(load_ready), 64'(0));
    chk({tag, "_mem_we"}, 64'(mem_we), 64'(0));
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
    chk({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(1));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_cycle_count"}, 64'(cycle_count), 64'(0));
    chk({tag, "_error"}, 64'(error), 64'(0));
  endtask

  // Start a session and stream the contents of words[].
  task automatic load_words(input bit use_last, input bit noise);
    int ptr;
    ptr = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    load_valid = 1'b0;
    @(negedge clk);
    chk("start_count", 64'(cycle_count), 64'(0));
    chk("start_error", 64'(error), 64'(0));
    chk("start_done", 64'(done), 64'(0));
    chk("load_busy", 64'(busy), 64'(1));
    chk("load_cpu_reset", 64'(cpu_reset), 64'(1));
    step();
    foreach (words[i]) begin
      if (noise) begin
        repeat ($urandom_range(0, 2)) begin
          load_valid = 1'b0;
          start = 1'($urandom_range(0, 1));
          EOE = 1'($urandom_range(0, 1));
          @(negedge clk);
          chk("ready_gap", 64'(load_ready), 64'(1));
          step();
        end
      end
      EOE = 1'b0;
      load_valid = 1'b1;
      load_data = words[i];
      load_last = use_last && (i == words.size() - 1);
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      chk("ready_hs", 64'(load_ready), 64'(1));
      exp_q.push_back('{ptr, int'(words[i]), cyc + 1});
      ptr++;
      step();
    end
    load_valid = 1'b0;
    load_last = 1'b0;
    start = 1'b0;
  endtask

  // Full session: load, boot, run until EOE on RUN cycle eoe_at (or the
  // watchdog), then verify DONE is held.
  task automatic session(input bit use_last, input bit noise, input int eoe_at);
    bit exp_err;
    int exp_cnt;
    load_words(use_last, noise);
    exp_err = !use_last;
    @(negedge clk);
    chk("boot_busy", 64'(busy), 64'(1));
    chk("boot_cpu_reset", 64'(cpu_reset), 64'(1));
    chk("boot_ready", 64'(load_ready), 64'(0));
    chk("boot_error", 64'(error), 64'(exp_err));
    step();
    exp_cnt = eoe_at;
    if (TO_EN && eoe_at > TO) begin
      exp_cnt = TO;
      exp_err = 1'b1;
    end
    for (int i = 1; i <= exp_cnt; i++) begin
      EOE = (i == eoe_at);
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (i == 1) begin
        chk("run_cpu_reset", 64'(cpu_reset), 64'(0));
        chk("run_busy", 64'(busy), 64'(1));
      end
      if (i == exp_cnt) chk("run_count", 64'(cycle_count), 64'(i - 1));
      step();
    end
    EOE = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("done_done", 64'(done), 64'(1));
    chk("done_busy", 64'(busy), 64'(0));
    chk("done_cpu_reset", 64'(cpu_reset), 64'(1));
    chk("done_count", 64'(cycle_count), 64'(exp_cnt));
    chk("done_error", 64'(error), 64'(exp_err));
    chk("done_ready", 64'(load_ready), 64'(0));
    chk("writes_drained", 64'(exp_q.size()), 64'(0));
    repeat (3) begin
      EOE = 1'($urandom_range(0, 1));
      step();
    end
    EOE = 1'b0;
    @(negedge clk);
    chk("hold_done", 64'(done), 64'(1));
    chk("hold_count", 64'(cycle_count), 64'(exp_cnt));
    chk("hold_error", 64'(error), 64'(exp_err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    reset_checks("rst");

    // Reference program, EOE on the 10th RUN cycle.
    words = '{16'h8105, 16'h0123, 16'hF0F0};
    session(1'b1, 1'b0, 10);

    // Gappy valid with start pulses during LOAD: two writes, no restart.
    words = '{16'h00A1, 16'h00B2};
    session(1'b1, 1'b1, 4);

    // Reset in the middle of RUN at cycle_count 5.
    words = '{16'h1234, 16'h5678};
    load_words(1'b1, 1'b0);
    step();                         // BOOT
    repeat (5) step();              // five RUN edges
    @(negedge clk);
    chk("midrun_count", 64'(cycle_count), 64'(5));
    reset = 1'b1;
    step();
    reset = 1'b0;
    reset_checks("midrun_rst");

    // Reset coinciding with a handshake abandons the write.
    start = 1'b1;
    step();
    start = 1'b0;
    load_valid = 1'b1;
    load_data = 16'hDEAD;
    reset = 1'b1;
    step();
    load_valid = 1'b0;
    reset = 1'b0;
    reset_checks("hs_rst");
    step();

    // Randomized sessions.
    for (int s = 0; s < 8; s++) begin
      int n;
      n = $urandom_range(1, 6);
      words.delete();
      for (int k = 0; k < n; k++) words.push_back(DW'($urandom));
      session(1'b1, 1'b1, $urandom_range(1, 30));
    end

    // Fill the whole memory without load_last: truncated load.
    words.delete();
    for (int k = 0; k < (1 << AW); k++) words.push_back(DW'($urandom));
    session(1'b0, 1'b0, 4);

    chk("final_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
